// File: rtl/alu_control_sequencer.sv
// rtl/alu_control_sequencer.sv - T-state sequencer for one register-register ALU instruction
// Moore decode: every output depends only on state, the latched IR fields and the T4 hold counter.
module alu_control_sequencer #(
   parameter int MUL_CYCLES = 1,
   parameter int DIV_CYCLES = 1
) (
   input  logic        Clock,
   input  logic        Clear,
   input  logic        Start,
   input  logic [31:0] IR,
   output logic [31:0] encIn,
   output logic [15:0] Rin,
   output logic        Yin,
   output logic        ZHIin,
   output logic        ZLOin,
   output logic        HIin,
   output logic        LOin,
   output logic [12:0] AluOp,
   output logic        Busy,
   output logic        Done,
   output logic        Illegal
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_T3   = 3'd1;
   localparam logic [2:0] S_T4   = 3'd2;
   localparam logic [2:0] S_T5   = 3'd3;
   localparam logic [2:0] S_T6   = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;
   localparam logic [4:0] OP_NEG = 5'b10001;
   localparam logic [4:0] OP_NOT = 5'b10010;

   localparam logic [3:0] MUL_LEN = 4'(MUL_CYCLES);
   localparam logic [3:0] DIV_LEN = 4'(DIV_CYCLES);

   function automatic logic [12:0] alu_onehot(input logic [4:0] op);
      logic [12:0] r;
      r = 13'd0;
      case (op)
         5'b01111: r[12] = 1'b1;
         5'b10000: r[11] = 1'b1;
         5'b01011: r[10] = 1'b1;
         5'b01010: r[9]  = 1'b1;
         5'b00100: r[8]  = 1'b1;
         5'b10001: r[7]  = 1'b1;
         5'b00011: r[6]  = 1'b1;
         5'b01001: r[5]  = 1'b1;
         5'b01000: r[4]  = 1'b1;
         5'b00111: r[3]  = 1'b1;
         5'b00101: r[2]  = 1'b1;
         5'b00110: r[1]  = 1'b1;
         5'b10010: r[0]  = 1'b1;
         default:  r     = 13'd0;
      endcase
      return r;
   endfunction

   logic [2:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [16:0] ir_q, ir_d;

   // only op/ra/rb/rc are latched; the low IR bits carry nothing for this class
   logic ir_low_unused;
   assign ir_low_unused = ^IR[14:0];

   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   logic       unary, muldiv, t4_last;
   logic [3:0] t4_len;

   assign op     = ir_q[16:12];
   assign ra     = ir_q[11:8];
   assign rb     = ir_q[7:4];
   assign rc     = ir_q[3:0];
   assign unary  = (op == OP_NEG) || (op == OP_NOT);
   assign muldiv = (op == OP_MUL) || (op == OP_DIV);
   assign t4_len = (op == OP_MUL) ? MUL_LEN : (op == OP_DIV) ? DIV_LEN : 4'd1;
   assign t4_last = (cnt_q == t4_len - 4'd1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ir_d    = ir_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = 4'd0;
            if (Start) begin
               ir_d = IR[31:15];
               if (alu_onehot(IR[31:27]) == 13'd0)
                  state_d = S_DONE;
               else if ((IR[31:27] == OP_NEG) || (IR[31:27] == OP_NOT))
                  state_d = S_T4;
               else
                  state_d = S_T3;
            end
         end
         S_T3: begin
            cnt_d   = 4'd0;
            state_d = S_T4;
         end
         S_T4: begin
            if (t4_last) begin
               cnt_d   = 4'd0;
               state_d = S_T5;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_T5:    state_d = muldiv ? S_T6 : S_DONE;
         S_T6:    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         ir_q    <= 17'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      encIn   = 32'd0;
      Rin     = 16'd0;
      Yin     = 1'b0;
      ZHIin   = 1'b0;
      ZLOin   = 1'b0;
      HIin    = 1'b0;
      LOin    = 1'b0;
      AluOp   = 13'd0;
      Busy    = (state_q != S_IDLE);
      Done    = 1'b0;
      Illegal = 1'b0;
      case (state_q)
         S_T3: begin
            encIn = 32'd1 << rb;
            Yin   = 1'b1;
         end
         S_T4: begin
            encIn = 32'd1 << (unary ? rb : rc);
            AluOp = alu_onehot(op);
            ZHIin = t4_last;
            ZLOin = t4_last;
         end
         S_T5: begin
            encIn[19] = 1'b1;
            LOin      = muldiv;
            Rin       = muldiv ? 16'd0 : (16'd1 << ra);
         end
         S_T6: begin
            encIn[18] = 1'b1;
            HIin      = 1'b1;
         end
         S_DONE: begin
            Done    = 1'b1;
            Illegal = (alu_onehot(op) == 13'd0);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb/tb_alu_control_sequencer.sv - directed per-cycle checks of the ALU control sequencer
module tb_alu_control_sequencer;

   logic        Clock, Clear, Start;
   logic [31:0] IR;
   logic [31:0] encIn;
   logic [15:0] Rin;
   logic        Yin, ZHIin, ZLOin, HIin, LOin;
   logic [12:0] AluOp;
   logic        Busy, Done, Illegal;

   int n_vec = 0;
   int n_err = 0;

   alu_control_sequencer #(.MUL_CYCLES(3), .DIV_CYCLES(2)) dut (
      .Clock(Clock), .Clear(Clear), .Start(Start), .IR(IR),
      .encIn(encIn), .Rin(Rin), .Yin(Yin), .ZHIin(ZHIin), .ZLOin(ZLOin),
      .HIin(HIin), .LOin(LOin), .AluOp(AluOp),
      .Busy(Busy), .Done(Done), .Illegal(Illegal)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic [68:0] obs;
   assign obs = {encIn, Rin, Yin, ZHIin, ZLOin, HIin, LOin, AluOp, Busy, Done, Illegal};

   // control group {Yin,ZHIin,ZLOin,HIin,LOin}, status group {Busy,Done,Illegal}
   localparam logic [4:0] C_Y = 5'b10000, C_Z = 5'b01100, C_HI = 5'b00010, C_LO = 5'b00001;
   localparam logic [2:0] S_B = 3'b100, S_D = 3'b110, S_DI = 3'b111;
   localparam logic [12:0] A_MUL = 13'h1000, A_DIV = 13'h0800, A_ADD = 13'h0040, A_NOT = 13'h0001;

   function automatic logic [68:0] ex(input logic [31:0] e, input logic [15:0] r,
                                      input logic [4:0] c, input logic [12:0] a, input logic [2:0] s);
      return {e, r, c, a, s};
   endfunction

   task automatic test_reset;
      Clear = 1'b0; Start = 1'b1; IR = 32'h18918000;
      #2;
      n_vec++;
      if (obs !== 69'd0) begin n_err++; $display("FAIL reset_async got %h want 0", obs); end
      @(posedge Clock); #1;
      n_vec++;
      if (obs !== 69'd0) begin n_err++; $display("FAIL reset_hold got %h want 0", obs); end
      Start = 1'b0; Clear = 1'b1;
      @(posedge Clock); #1;
      n_vec++;
      if (obs !== 69'd0) begin n_err++; $display("FAIL reset_idle got %h want 0", obs); end
   endtask

   task automatic test_add;
      logic [68:0] want [5];
      want[0] = ex(32'h4, 16'h0, C_Y, 13'h0, S_B);
      want[1] = ex(32'h8, 16'h0, C_Z, A_ADD, S_B);
      want[2] = ex(32'h80000, 16'h2, 5'h0, 13'h0, S_B);
      want[3] = ex(32'h0, 16'h0, 5'h0, 13'h0, S_D);
      want[4] = 69'd0;
      IR = 32'h18918000; Start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge Clock); #1; Start = 1'b0;
         n_vec++;
         if (obs !== want[i]) begin n_err++; $display("FAIL add cyc%0d got %h want %h", i, obs, want[i]); end
      end
   endtask

   task automatic test_mul;
      logic [68:0] want [8];
      want[0] = ex(32'h40, 16'h0, C_Y, 13'h0, S_B);
      want[1] = ex(32'h80, 16'h0, 5'h0, A_MUL, S_B);
      want[2] = ex(32'h80, 16'h0, 5'h0, A_MUL, S_B);
      want[3] = ex(32'h80, 16'h0, C_Z, A_MUL, S_B);
      want[4] = ex(32'h80000, 16'h0, C_LO, 13'h0, S_B);
      want[5] = ex(32'h40000, 16'h0, C_HI, 13'h0, S_B);
      want[6] = ex(32'h0, 16'h0, 5'h0, 13'h0, S_D);
      want[7] = 69'd0;
      IR = 32'h78338000; Start = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge Clock); #1; Start = 1'b0;
         n_vec++;
         if (obs !== want[i]) begin n_err++; $display("FAIL mul cyc%0d got %h want %h", i, obs, want[i]); end
      end
   endtask

   task automatic test_div;
      logic [68:0] want [7];
      want[0] = ex(32'h4, 16'h0, C_Y, 13'h0, S_B);
      want[1] = ex(32'h8, 16'h0, 5'h0, A_DIV, S_B);
      want[2] = ex(32'h8, 16'h0, C_Z, A_DIV, S_B);
      want[3] = ex(32'h80000, 16'h0, C_LO, 13'h0, S_B);
      want[4] = ex(32'h40000, 16'h0, C_HI, 13'h0, S_B);
      want[5] = ex(32'h0, 16'h0, 5'h0, 13'h0, S_D);
      want[6] = 69'd0;
      IR = 32'h82918000; Start = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(posedge Clock); #1; Start = 1'b0;
         n_vec++;
         if (obs !== want[i]) begin n_err++; $display("FAIL div cyc%0d got %h want %h", i, obs, want[i]); end
      end
   endtask

   task automatic test_not;
      logic [68:0] want [4];
      want[0] = ex(32'h200, 16'h0, C_Z, A_NOT, S_B);
      want[1] = ex(32'h80000, 16'h10, 5'h0, 13'h0, S_B);
      want[2] = ex(32'h0, 16'h0, 5'h0, 13'h0, S_D);
      want[3] = 69'd0;
      IR = 32'h92480000; Start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge Clock); #1; Start = 1'b0;
         n_vec++;
         if (obs !== want[i]) begin n_err++; $display("FAIL not cyc%0d got %h want %h", i, obs, want[i]); end
      end
   endtask

   task automatic test_illegal;
      logic [68:0] want [2];
      want[0] = ex(32'h0, 16'h0, 5'h0, 13'h0, S_DI);
      want[1] = 69'd0;
      IR = 32'h00000000; Start = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge Clock); #1; Start = 1'b0;
         n_vec++;
         if (obs !== want[i]) begin n_err++; $display("FAIL illegal cyc%0d got %h want %h", i, obs, want[i]); end
      end
   endtask

   task automatic test_clear_mid;
      IR = 32'h78338000; Start = 1'b1;
      @(posedge Clock); #1; Start = 1'b0;
      @(posedge Clock); #1;
      n_vec++;
      if (obs !== ex(32'h80, 16'h0, 5'h0, A_MUL, S_B)) begin
         n_err++; $display("FAIL clr_pre_t4 got %h want %h", obs, ex(32'h80, 16'h0, 5'h0, A_MUL, S_B));
      end
      Clear = 1'b0;
      #1;
      n_vec++;
      if (obs !== 69'd0) begin n_err++; $display("FAIL clr_async got %h want 0", obs); end
      @(posedge Clock); #1;
      n_vec++;
      if (obs !== 69'd0) begin n_err++; $display("FAIL clr_held got %h want 0", obs); end
      Clear = 1'b1;
      @(posedge Clock); #1;
      n_vec++;
      if (obs !== 69'd0) begin n_err++; $display("FAIL clr_no_done got %h want 0", obs); end
   endtask

   task automatic test_back_to_back;
      logic [68:0] want [10];
      want[0] = ex(32'h4, 16'h0, C_Y, 13'h0, S_B);
      want[1] = ex(32'h8, 16'h0, C_Z, A_ADD, S_B);
      want[2] = ex(32'h80000, 16'h2, 5'h0, 13'h0, S_B);
      want[3] = ex(32'h0, 16'h0, 5'h0, 13'h0, S_D);
      want[4] = 69'd0;
      for (int i = 5; i < 10; i++) want[i] = want[i-5];
      IR = 32'h18918000; Start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge Clock); #1;
         if (i == 8) Start = 1'b0;
         n_vec++;
         if (obs !== want[i]) begin n_err++; $display("FAIL b2b cyc%0d got %h want %h", i, obs, want[i]); end
      end
      // stray Start pulses with a different IR while busy must not disturb the latched ADD
      IR = 32'h18918000; Start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge Clock); #1;
         IR = 32'h92480000;
         Start = (i == 0 || i == 2);
         n_vec++;
         if (obs !== want[i]) begin n_err++; $display("FAIL stray cyc%0d got %h want %h", i, obs, want[i]); end
      end
      Start = 1'b0;
      @(posedge Clock); #1;
      n_vec++;
      if (obs !== 69'd0) begin n_err++; $display("FAIL stray_idle got %h want 0", obs); end
   endtask

   initial begin
      Clear = 1'b0; Start = 1'b0; IR = 32'd0;
      @(posedge Clock); #1;
      test_reset;
      test_add;
      test_mul;
      test_div;
      test_not;
      test_illegal;
      test_clear_mid;
      test_add;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
